alu_result_packer: RTL and testbench
====================================

ALU_RESULT_PACKER -- requirements
Module: alu_result_packer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, the byte width of the TX FIFO write port; ALU result width is 2*DATA_WIDTH.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port ALU_OUT  input  2*DATA_WIDTH  ALU result, sampled only when OUT_VALID=1.
REQ-005 SHALL have port OUT_VALID  input  1  one-cycle pulse marking ALU_OUT valid.
REQ-006 SHALL have port WIDE_RES  input  1  sampled with OUT_VALID; 1 = send both bytes, 0 = send low byte only.
REQ-007 SHALL have port FIFO_FULL  input  1  TX FIFO full; blocks writes.
REQ-008 SHALL have port CLR_OVR  input  1  synchronous clear of OVERRUN.
REQ-009 SHALL have port WR_DATA  output  DATA_WIDTH  byte to TX FIFO.
REQ-010 SHALL have port WR_INC  output  1  FIFO write strobe, one cycle per byte.
REQ-011 SHALL have port BUSY  output  1  packer holds an unsent result.
REQ-012 SHALL have port OVERRUN  output  1  sticky: a result was dropped.

Function
REQ-013 SHALL implement states IDLE, SEND_LO, SEND_HI; BUSY = (state != IDLE).
REQ-014 SHALL define accept = OUT_VALID & (IDLE | final byte written this cycle); on accept, capture ALU_OUT into hold register and WIDE_RES into wide flag, next state SEND_LO.
REQ-015 SHALL, in SEND_LO/SEND_HI, drive WR_INC = ~FIFO_FULL combinationally; WR_DATA = hold[DATA_WIDTH-1:0] in SEND_LO, hold[2*DATA_WIDTH-1:DATA_WIDTH] in SEND_HI, zero in IDLE.
REQ-016 SHALL, in SEND_LO with write: go to SEND_HI if wide=1, else IDLE (or SEND_LO on accept); with FIFO_FULL stay, holding WR_DATA stable.
REQ-017 SHALL, in SEND_HI with write: go to IDLE (or SEND_LO on accept); with FIFO_FULL stay.
REQ-018 SHALL give latency OUT_VALID at edge N -> low byte WR_INC in cycle N+1, high byte N+2 when FIFO never full.
REQ-019 SHALL, when OUT_VALID=1 and accept=0, ignore ALU_OUT, keep the in-progress transfer intact, and set OVERRUN at next edge.
REQ-020 SHALL give OVERRUN set priority over CLR_OVR in the same cycle.
REQ-021 SHALL never assert WR_INC while FIFO_FULL=1 and never write a byte twice.

Reset
REQ-022 SHALL, on rst high, immediately force state IDLE, hold register 0, wide flag 0, OVERRUN 0; hence WR_INC=0, WR_DATA=0, BUSY=0 without a clock edge.
REQ-023 SHALL discard any partially sent result on reset mid-transfer; no remaining byte is written after release.
REQ-024 SHALL ignore OUT_VALID coincident with rst.

Structure
REQ-025 SHALL take state encoding constants (IDLE=2'b00, SEND_LO=2'b01, SEND_HI=2'b10) and DATA_WIDTH default from the shared system package.
REQ-026 SHALL be a single flat module; no sub-module is natural.

Verification
REQ-027 Wide result: ALU_OUT=16'hA55A, WIDE_RES=1, FIFO_FULL=0 -> WR_INC cycles N+1 (WR_DATA=8'h5A), N+2 (8'hA5), BUSY low at N+3.
REQ-028 Narrow result: ALU_OUT=16'h00C3, WIDE_RES=0 -> single WR_INC with 8'hC3 at N+1, no second write.
REQ-029 Backpressure: FIFO_FULL=1 for 3 cycles after OUT_VALID with 16'h1234 -> WR_INC stays 0, WR_DATA held 8'h34; after release 8'h34 then 8'h12, each exactly once.
REQ-030 Back-to-back: second OUT_VALID (16'hBEEF) in the cycle the high byte of 16'h1234 is written -> bytes 34,12,EF,BE contiguous, OVERRUN=0.
REQ-031 Overrun: OUT_VALID in SEND_LO -> OVERRUN=1 next cycle, original bytes still sent; CLR_OVR=1 with no new overrun -> OVERRUN=0; CLR_OVR with simultaneous overrun -> stays 1.
REQ-032 Reset mid-transfer: rst pulsed in SEND_HI -> WR_INC=0, BUSY=0 immediately, no further writes until next OUT_VALID.

Source files
------------

// File: rtl/alu_result_packer_pkg.sv
// Shared constants and types for the ALU result packer.
package alu_result_packer_pkg;

  // Default TX FIFO byte width; the ALU result is twice this wide.
  localparam int unsigned DATA_WIDTH_DEFAULT = 8;

  // Packer state encoding shared with the rest of the system.
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    SEND_LO = 2'b01,
    SEND_HI = 2'b10
  } state_t;

endpackage

// File: rtl/alu_result_packer.sv
// Splits an ALU result into one or two bytes and writes them to the TX FIFO,
// honouring FIFO backpressure and flagging results that arrive while busy.
module alu_result_packer
  import alu_result_packer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    OUT_VALID,
  input  logic                    WIDE_RES,
  input  logic                    FIFO_FULL,
  input  logic                    CLR_OVR,
  output logic [DATA_WIDTH-1:0]   WR_DATA,
  output logic                    WR_INC,
  output logic                    BUSY,
  output logic                    OVERRUN
);

  localparam int unsigned RES_W = 2 * DATA_WIDTH;

  state_t               state;
  state_t               state_nxt;
  logic [RES_W-1:0]     hold;
  logic [RES_W-1:0]     hold_nxt;
  logic                 wide;
  logic                 wide_nxt;
  logic                 overrun_q;
  logic                 overrun_nxt;
  logic                 wr_en;
  logic [DATA_WIDTH-1:0] wr_byte;
  logic                 final_wr;
  logic                 accept;

  // Next-state, byte selection, accept and overrun decisions.
  always_comb begin
    state_nxt   = state;
    hold_nxt    = hold;
    wide_nxt    = wide;
    overrun_nxt = overrun_q;
    wr_en       = 1'b0;
    wr_byte     = '0;
    final_wr    = 1'b0;
    accept      = 1'b0;

    case (state)
      IDLE: ;
      SEND_LO: begin
        wr_en   = ~FIFO_FULL;
        wr_byte = hold[DATA_WIDTH-1:0];
        if (~FIFO_FULL) begin
          final_wr  = ~wide;
          state_nxt = wide ? SEND_HI : IDLE;
        end
      end
      SEND_HI: begin
        wr_en   = ~FIFO_FULL;
        wr_byte = hold[RES_W-1:DATA_WIDTH];
        if (~FIFO_FULL) begin
          final_wr  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // A new result is taken when idle or when the last byte leaves this cycle.
    accept = OUT_VALID & ((state == IDLE) | final_wr);
    if (accept) begin
      hold_nxt  = ALU_OUT;
      wide_nxt  = WIDE_RES;
      state_nxt = SEND_LO;
    end

    // A dropped result wins over a clear request in the same cycle.
    if (OUT_VALID & ~accept) begin
      overrun_nxt = 1'b1;
    end else if (CLR_OVR) begin
      overrun_nxt = 1'b0;
    end
  end

  // State, captured result and sticky overrun flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      hold      <= '0;
      wide      <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      hold      <= hold_nxt;
      wide      <= wide_nxt;
      overrun_q <= overrun_nxt;
    end
  end

  assign WR_INC  = wr_en;
  assign WR_DATA = wr_byte;
  assign BUSY    = (state != IDLE);
  assign OVERRUN = overrun_q;

endmodule

// File: tb/tb_alu_result_packer.sv
// Directed bench for alu_result_packer with a queue-based reference model.
module tb_alu_result_packer;

  localparam int unsigned DW = 8;

  logic          clk;
  logic          rst;
  logic [2*DW-1:0] alu_out;
  logic          out_valid;
  logic          wide_res;
  logic          fifo_full;
  logic          clr_ovr;
  logic [DW-1:0] wr_data;
  logic          wr_inc;
  logic          busy;
  logic          overrun;

  int vectors;
  int errors;

  alu_result_packer #(.DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .ALU_OUT   (alu_out),
    .OUT_VALID (out_valid),
    .WIDE_RES  (wide_res),
    .FIFO_FULL (fifo_full),
    .CLR_OVR   (clr_ovr),
    .WR_DATA   (wr_data),
    .WR_INC    (wr_inc),
    .BUSY      (busy),
    .OVERRUN   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the bytes still owed to the FIFO, oldest first.
  logic [DW-1:0] m_q[$];
  logic          m_ovr;
  logic [2*DW-1:0] m_res;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_ovr = 1'b0;
    end else begin
      if (m_q.size() != 0 && !fifo_full) void'(m_q.pop_front());
      if (out_valid && m_q.size() == 0) begin
        m_res = alu_out;
        m_q.push_back(m_res[DW-1:0]);
        if (wide_res) m_q.push_back(m_res[2*DW-1:DW]);
      end else if (out_valid) begin
        m_ovr = 1'b1;
      end else if (clr_ovr) begin
        m_ovr = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Every mid-cycle, outputs must match the model.
  logic          e_busy;
  logic          e_inc;
  logic [DW-1:0] e_data;
  always @(negedge clk) begin
    if (!rst) begin
      e_busy = (m_q.size() != 0);
      e_inc  = e_busy && !fifo_full;
      e_data = e_busy ? m_q[0] : '0;
      check("model_busy",    16'(busy),    16'(e_busy));
      check("model_wr_inc",  16'(wr_inc),  16'(e_inc));
      check("model_wr_data", 16'(wr_data), 16'(e_data));
      check("model_overrun", 16'(overrun), 16'(m_ovr));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [15:0] data, input logic wide);
    alu_out   = data;
    wide_res  = wide;
    out_valid = 1'b1;
    tick();
    out_valid = 1'b0;
  endtask

  initial begin
    vectors   = 0;
    errors    = 0;
    rst       = 1'b1;
    alu_out   = '0;
    out_valid = 1'b0;
    wide_res  = 1'b0;
    fifo_full = 1'b0;
    clr_ovr   = 1'b0;
    #1;
    check("rst_wr_inc",  16'(wr_inc),  16'h0);
    check("rst_wr_data", 16'(wr_data), 16'h0);
    check("rst_busy",    16'(busy),    16'h0);
    check("rst_overrun", 16'(overrun), 16'h0);
    tick();
    rst = 1'b0;
    tick();

    // Wide result: low byte then high byte on consecutive cycles.
    pulse(16'hA55A, 1'b1);
    check("wide_lo_inc",  16'(wr_inc),  16'h1);
    check("wide_lo_data", 16'(wr_data), 16'h5A);
    tick();
    check("wide_hi_inc",  16'(wr_inc),  16'h1);
    check("wide_hi_data", 16'(wr_data), 16'hA5);
    tick();
    check("wide_done_busy", 16'(busy), 16'h0);
    tick();

    // Narrow result: single write.
    pulse(16'h00C3, 1'b0);
    check("narrow_inc",  16'(wr_inc),  16'h1);
    check("narrow_data", 16'(wr_data), 16'hC3);
    tick();
    check("narrow_no_second", 16'(wr_inc), 16'h0);
    check("narrow_idle",      16'(busy),   16'h0);
    tick();

    // Backpressure: three full cycles, byte held stable.
    fifo_full = 1'b1;
    pulse(16'h1234, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check("bp_hold_inc",  16'(wr_inc),  16'h0);
      check("bp_hold_data", 16'(wr_data), 16'h34);
      if (i < 2) tick();
    end
    fifo_full = 1'b0;
    #1;
    check("bp_lo_inc",  16'(wr_inc),  16'h1);
    check("bp_lo_data", 16'(wr_data), 16'h34);
    tick();
    check("bp_hi_data", 16'(wr_data), 16'h12);
    tick();
    check("bp_idle", 16'(busy), 16'h0);
    tick();

    // Back-to-back: next result arrives as the high byte leaves.
    pulse(16'h1234, 1'b1);
    check("b2b_b0", 16'(wr_data), 16'h34);
    tick();
    alu_out   = 16'hBEEF;
    wide_res  = 1'b1;
    out_valid = 1'b1;
    check("b2b_b1", 16'(wr_data), 16'h12);
    tick();
    out_valid = 1'b0;
    check("b2b_b2_inc", 16'(wr_inc),  16'h1);
    check("b2b_b2",     16'(wr_data), 16'hEF);
    tick();
    check("b2b_b3", 16'(wr_data), 16'hBE);
    check("b2b_ovr", 16'(overrun), 16'h0);
    tick();
    check("b2b_idle", 16'(busy), 16'h0);
    tick();

    // Overrun: a result arriving in SEND_LO of a wide transfer is dropped.
    pulse(16'h5678, 1'b1);
    alu_out   = 16'h9999;
    out_valid = 1'b1;
    tick();
    out_valid = 1'b0;
    check("ovr_set",     16'(overrun), 16'h1);
    check("ovr_orig_hi", 16'(wr_data), 16'h56);
    tick();
    check("ovr_drained", 16'(busy), 16'h0);
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    check("ovr_cleared", 16'(overrun), 16'h0);

    // Clear coincident with a new overrun: set wins.
    pulse(16'h0F0F, 1'b1);
    alu_out   = 16'h7777;
    out_valid = 1'b1;
    clr_ovr   = 1'b1;
    tick();
    out_valid = 1'b0;
    clr_ovr   = 1'b0;
    check("ovr_set_wins", 16'(overrun), 16'h1);
    check("ovr_set_hi",   16'(wr_data), 16'h0F);
    tick();
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    check("ovr_cleared2", 16'(overrun), 16'h0);

    // Reset mid-transfer while in SEND_HI.
    pulse(16'hABCD, 1'b1);
    tick();
    check("rstmid_in_hi", 16'(wr_data), 16'hAB);
    #2;
    rst = 1'b1;
    #1;
    check("rstmid_inc",  16'(wr_inc),  16'h0);
    check("rstmid_busy", 16'(busy),    16'h0);
    check("rstmid_data", 16'(wr_data), 16'h0);
    // A valid pulse during reset is ignored.
    alu_out   = 16'h4242;
    wide_res  = 1'b1;
    out_valid = 1'b1;
    tick();
    out_valid = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rstmid_quiet_inc",  16'(wr_inc), 16'h0);
      check("rstmid_quiet_busy", 16'(busy),   16'h0);
    end

    // Transfer after reset works normally.
    pulse(16'h2211, 1'b0);
    check("post_rst_data", 16'(wr_data), 16'h11);
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
